// File: rtl/f1_pkg.sv
// ----------------------------------------------------------------------------
// f1_pkg
// Shared types and constants for the race-start controller:
//   ctrl_state_t : controller state encoding
//   LFSR_W       : width of the random-delay LFSR
//   LFSR_TAPS    : feedback tap mask for x^7 + x^6 + 1 (register bits 6 and 5)
//   LFSR_SEED    : reset value of the LFSR (must be non-zero)
//   LIGHTS_ALL   : all eight gantry lamps lit
//   lfsr_next()  : one Fibonacci shift step
// ----------------------------------------------------------------------------
package f1_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COUNTUP = 3'd1,
      HOLD    = 3'd2,
      RUN     = 3'd3,
      DONE    = 3'd4,
      FOUL    = 3'd5
   } ctrl_state_t;

   localparam int              LFSR_W     = 7;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
   localparam logic [7:0]      LIGHTS_ALL = 8'hFF;

   // Shift left, feeding the XOR of the tapped bits into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/f1_lfsr7.sv
// ----------------------------------------------------------------------------
// f1_lfsr7
// Free-running 7-bit Fibonacci LFSR (x^7 + x^6 + 1), shifting every clock.
// Maximal length (127 states), so it never reaches zero from a non-zero seed.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset, loads LFSR_SEED
//   lfsr : current register value
// ----------------------------------------------------------------------------
module f1_lfsr7
   import f1_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   output logic [LFSR_W-1:0] lfsr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr_next(lfsr);
   end

endmodule

// File: rtl/f1_start_ctrl.sv
// ----------------------------------------------------------------------------
// f1_start_ctrl
// Race-start controller for the 8-light gantry. A start request lights one
// lamp per tick, holds all eight for a random 1..127 ticks, then turns them
// off and counts the reaction time in clock cycles. A trigger before
// lights-out is reported as a foul.
// Parameters:
//   TICK_CYCLES : clk cycles per light tick (>= 2)
//   REACT_W     : width of reaction counter / react_time
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : start request (pulse or level), accepted in IDLE/DONE/FOUL
//   trigger     : driver button (synchronised)
//   lights      : thermometer lamp pattern, bit 0 first
//   tick        : one-cycle pulse at each prescaler wrap
//   react_time  : captured reaction time (all-ones on timeout)
//   react_valid : react_time valid, held until next start
//   foul        : jump start, held until next start
//   busy        : sequence in progress (COUNTUP, HOLD, RUN)
// ----------------------------------------------------------------------------
module f1_start_ctrl
   import f1_pkg::*;
#(
   parameter int TICK_CYCLES = 1000,
   parameter int REACT_W     = 16
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               trigger,
   output logic [7:0]         lights,
   output logic               tick,
   output logic [REACT_W-1:0] react_time,
   output logic               react_valid,
   output logic               foul,
   output logic               busy
);

   localparam int            PW         = $clog2(TICK_CYCLES);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

   ctrl_state_t        state, state_nxt;
   logic [PW-1:0]      presc, presc_nxt;
   logic [7:0]         lights_nxt;
   logic [LFSR_W-1:0]  delay_cnt, delay_nxt;
   logic [REACT_W-1:0] cnt, cnt_nxt;
   logic [REACT_W-1:0] react_time_nxt;
   logic               react_valid_nxt, foul_nxt;
   logic [LFSR_W-1:0]  lfsr;
   logic               counting;

   f1_lfsr7 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   // The prescaler only runs while lamps are being lit or held.
   assign counting = (state == COUNTUP) || (state == HOLD);
   assign tick     = counting && (presc == PRESC_LAST);
   assign busy     = counting || (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         presc       <= '0;
         lights      <= '0;
         delay_cnt   <= '0;
         cnt         <= '0;
         react_time  <= '0;
         react_valid <= 1'b0;
         foul        <= 1'b0;
      end else begin
         state       <= state_nxt;
         presc       <= presc_nxt;
         lights      <= lights_nxt;
         delay_cnt   <= delay_nxt;
         cnt         <= cnt_nxt;
         react_time  <= react_time_nxt;
         react_valid <= react_valid_nxt;
         foul        <= foul_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      lights_nxt      = lights;
      delay_nxt       = delay_cnt;
      cnt_nxt         = cnt;
      react_time_nxt  = react_time;
      react_valid_nxt = react_valid;
      foul_nxt        = foul;
      presc_nxt       = '0;
      if (counting) presc_nxt = tick ? '0 : presc + 1'b1;

      case (state)
         IDLE, DONE, FOUL: begin
            // start beats a simultaneous trigger; trigger alone is ignored here
            if (start) begin
               state_nxt       = COUNTUP;
               presc_nxt       = '0;
               lights_nxt      = '0;
               react_valid_nxt = 1'b0;
               foul_nxt        = 1'b0;
               cnt_nxt         = '0;
            end
         end
         COUNTUP: begin
            if (trigger) begin
               state_nxt  = FOUL;
               lights_nxt = '0;
               foul_nxt   = 1'b1;
            end else if (tick) begin
               lights_nxt = {lights[6:0], 1'b1};
               // lights[6:0] all set means this shift completes the gantry
               if (lights[6:0] == LIGHTS_ALL[6:0]) begin
                  state_nxt = HOLD;
                  delay_nxt = lfsr;
               end
            end
         end
         HOLD: begin
            if (trigger) begin
               state_nxt  = FOUL;
               lights_nxt = '0;
               foul_nxt   = 1'b1;
            end else if (tick) begin
               if (delay_cnt == LFSR_W'(1)) begin
                  state_nxt  = RUN;
                  lights_nxt = '0;
                  cnt_nxt    = '0;
               end else begin
                  delay_nxt = delay_cnt - 1'b1;
               end
            end
         end
         RUN: begin
            if (trigger) begin
               state_nxt       = DONE;
               react_time_nxt  = cnt;
               react_valid_nxt = 1'b1;
            end else if (cnt == '1) begin
               state_nxt       = DONE;
               react_time_nxt  = '1;
               react_valid_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_f1_start_ctrl.sv
module tb_f1_start_ctrl;

   localparam int TICK    = 4;
   localparam int RW      = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          trigger = 1'b0;
   logic [7:0]    lights;
   logic          tick;
   logic [RW-1:0] react_time;
   logic          react_valid;
   logic          foul;
   logic          busy;

   int n_chk  = 0;
   int n_pass = 0;
   int ncyc   = 0;   // clock edges since reset release = LFSR shift count

   f1_start_ctrl #(.TICK_CYCLES(TICK), .REACT_W(RW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .trigger     (trigger),
      .lights      (lights),
      .tick        (tick),
      .react_time  (react_time),
      .react_valid (react_valid),
      .foul        (foul),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) ncyc <= 0;
      else     ncyc <= ncyc + 1;
   end

   // ---------------- reference model ----------------
   // LFSR value after n shifts from seed 1 with polynomial x^7+x^6+1 (period 127).
   function automatic logic [6:0] lfsr_at(input int n);
      logic [6:0] v;
      v = 7'h01;
      for (int i = 0; i < (n % 127); i++) v = {v[5:0], v[6] ^ v[5]};
      return v;
   endfunction

   // Lamp pattern c cycles after the start was accepted (c >= 1), during count-up.
   function automatic logic [7:0] lamps_at(input int c);
      int lit;
      lit = (c - 1) / TICK;
      if (lit > 8) lit = 8;
      return 8'((16'h1 << lit) - 1);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      start = 1'b0; trigger = 1'b0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   // Pulse start during cycle 0; returns at cycle 1.
   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Start a sequence and stop in the first HOLD cycle (cycle 33); d = predicted delay.
   task automatic go_to_hold(output int d);
      pulse_start();
      repeat (8 * TICK - 1) step();   // now at cycle 32, final count-up tick
      d = int'(lfsr_at(ncyc));
      step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int bad;
      rst = 1'b1;
      #2;
      n_chk++;
      if ({lights, tick, react_time, react_valid, foul, busy} !== '0)
         $display("FAIL reset_outputs got=%h want=0",
                  {lights, tick, react_time, react_valid, foul, busy});
      else n_pass++;
      step(); step();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         n_chk++;
         if (dut.u_lfsr.lfsr !== lfsr_at(ncyc)) begin
            $display("FAIL reset_lfsr cyc=%0d got=%h want=%h", ncyc, dut.u_lfsr.lfsr, lfsr_at(ncyc));
         end else n_pass++;
         if (lights !== 8'h00 || busy !== 1'b0 || foul !== 1'b0 || react_valid !== 1'b0) bad++;
         step();
      end
      n_chk++;
      if (bad != 0) $display("FAIL reset_idle_outputs bad_cycles=%0d want=0", bad);
      else n_pass++;
   endtask

   task automatic test_countup_and_react();
      int d, bad_l, bad_t;
      apply_reset();
      step();
      pulse_start();                       // cycle 1
      n_chk++;
      if (busy !== 1'b1) $display("FAIL busy_cycle1 got=%b want=1", busy);
      else n_pass++;
      bad_l = 0; bad_t = 0; d = 0;
      for (int c = 1; c <= 33; c++) begin
         if (lights !== lamps_at(c)) begin
            bad_l++;
            $display("FAIL countup_lights c=%0d got=%h want=%h", c, lights, lamps_at(c));
         end
         if (tick !== ((c % TICK == 0) && c <= 32)) begin
            bad_t++;
            $display("FAIL countup_tick c=%0d got=%b", c, tick);
         end
         if (c == 32) d = int'(lfsr_at(ncyc));
         if (c < 33) step();
      end
      n_chk++; if (bad_l == 0) n_pass++;
      n_chk++; if (bad_t == 0) n_pass++;
      // now at cycle 33 = first HOLD cycle
      repeat (TICK * d - 1) step();
      n_chk++;
      if (lights !== 8'hFF || busy !== 1'b1) $display("FAIL hold_last_cycle lights=%h busy=%b want=ff/1", lights, busy);
      else n_pass++;
      step();                              // first RUN cycle
      n_chk++;
      if (lights !== 8'h00 || busy !== 1'b1) $display("FAIL lights_out d=%0d lights=%h busy=%b want=00/1", d, lights, busy);
      else n_pass++;
      repeat (10) step();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      n_chk++;
      if (react_time !== 4'd10 || react_valid !== 1'b1 || busy !== 1'b0 || foul !== 1'b0)
         $display("FAIL react10 time=%0d valid=%b busy=%b foul=%b want=10/1/0/0", react_time, react_valid, busy, foul);
      else n_pass++;
      trigger = 1'b1;                      // ignored in DONE
      repeat (5) step();
      trigger = 1'b0;
      n_chk++;
      if (react_time !== 4'd10 || react_valid !== 1'b1 || busy !== 1'b0)
         $display("FAIL react_hold time=%0d valid=%b busy=%b want=10/1/0", react_time, react_valid, busy);
      else n_pass++;
      pulse_start();
      n_chk++;
      if (react_valid !== 1'b0 || busy !== 1'b1) $display("FAIL restart_clear valid=%b busy=%b want=0/1", react_valid, busy);
      else n_pass++;
   endtask

   task automatic test_foul_hold();
      int d;
      apply_reset();
      go_to_hold(d);
      repeat (TICK * d - 1) step();        // last HOLD cycle: trigger coincides with lights-out tick
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      n_chk++;
      if (foul !== 1'b1 || lights !== 8'h00 || react_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL foul_hold foul=%b lights=%h valid=%b busy=%b want=1/00/0/0", foul, lights, react_valid, busy);
      else n_pass++;
      repeat (6) step();
      n_chk++;
      if (foul !== 1'b1 || busy !== 1'b0) $display("FAIL foul_held foul=%b busy=%b want=1/0", foul, busy);
      else n_pass++;
   endtask

   task automatic test_foul_final_tick();
      int saw_ff;
      apply_reset();
      saw_ff = 0;
      pulse_start();
      for (int c = 1; c < 32; c++) begin
         if (lights === 8'hFF) saw_ff++;
         step();
      end
      trigger = 1'b1;                      // cycle 32: final tick
      step();
      trigger = 1'b0;
      n_chk++;
      if (foul !== 1'b1 || lights !== 8'h00) $display("FAIL foul_final_tick foul=%b lights=%h want=1/00", foul, lights);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         if (lights === 8'hFF) saw_ff++;
         step();
      end
      n_chk++;
      if (saw_ff != 0) $display("FAIL never_all_lit ff_cycles=%0d want=0", saw_ff);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int d;
      apply_reset();
      go_to_hold(d);
      repeat (TICK * d) step();            // first RUN cycle, counter 0
      repeat (15) step();                  // counter 15
      n_chk++;
      if (busy !== 1'b1 || react_valid !== 1'b0) $display("FAIL timeout_pre busy=%b valid=%b want=1/0", busy, react_valid);
      else n_pass++;
      step();
      n_chk++;
      if (busy !== 1'b0 || react_valid !== 1'b1 || react_time !== 4'hF || foul !== 1'b0)
         $display("FAIL timeout busy=%b valid=%b time=%h foul=%b want=0/1/f/0", busy, react_valid, react_time, foul);
      else n_pass++;
   endtask

   task automatic test_rst_mid_hold();
      int d;
      go_to_hold(d);                       // leaves react_time=F from the timeout test
      step(); step();
      rst = 1'b1;
      #1;
      n_chk++;
      if ({lights, tick, react_time, react_valid, foul, busy} !== '0)
         $display("FAIL rst_mid_hold got=%h want=0", {lights, tick, react_time, react_valid, foul, busy});
      else n_pass++;
      step();
      rst = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      n_chk++;
      if (busy !== 1'b1 || lights !== 8'h00) $display("FAIL start_after_rst busy=%b lights=%h want=1/00", busy, lights);
      else n_pass++;
      trigger = 1'b1;                      // abort into FOUL for the random test
      step();
      trigger = 1'b0;
   endtask

   task automatic test_random();
      int mode, c, k, d, off;
      for (int it = 0; it < 16; it++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0: begin                       // foul during count-up
               c = int'($urandom_range(1, 32));
               pulse_start();
               repeat (c - 1) step();
               n_chk++;
               if (lights !== lamps_at(c)) $display("FAIL rnd_countup c=%0d got=%h want=%h", c, lights, lamps_at(c));
               else n_pass++;
               trigger = 1'b1; step(); trigger = 1'b0;
               n_chk++;
               if (foul !== 1'b1 || lights !== 8'h00 || busy !== 1'b0)
                  $display("FAIL rnd_foul_cu c=%0d foul=%b lights=%h busy=%b", c, foul, lights, busy);
               else n_pass++;
            end
            1: begin                       // foul somewhere in HOLD
               go_to_hold(d);
               off = int'($urandom_range(0, TICK * d - 1));
               repeat (off) step();
               n_chk++;
               if (lights !== 8'hFF) $display("FAIL rnd_hold_lights off=%0d got=%h want=ff", off, lights);
               else n_pass++;
               trigger = 1'b1; step(); trigger = 1'b0;
               n_chk++;
               if (foul !== 1'b1 || lights !== 8'h00 || react_valid !== 1'b0)
                  $display("FAIL rnd_foul_hold off=%0d foul=%b lights=%h valid=%b", off, foul, lights, react_valid);
               else n_pass++;
            end
            2: begin                       // reaction at random count
               k = int'($urandom_range(0, 14));
               go_to_hold(d);
               repeat (TICK * d + k) step();
               trigger = 1'b1; step(); trigger = 1'b0;
               n_chk++;
               if (react_time !== RW'(k) || react_valid !== 1'b1 || foul !== 1'b0 || busy !== 1'b0)
                  $display("FAIL rnd_react k=%0d time=%0d valid=%b foul=%b busy=%b", k, react_time, react_valid, foul, busy);
               else n_pass++;
            end
            default: begin                 // start and trigger together: start wins
               start = 1'b1; trigger = 1'b1;
               step();
               start = 1'b0; trigger = 1'b0;
               n_chk++;
               if (busy !== 1'b1 || foul !== 1'b0 || react_valid !== 1'b0)
                  $display("FAIL rnd_start_wins busy=%b foul=%b valid=%b want=1/0/0", busy, foul, react_valid);
               else n_pass++;
               trigger = 1'b1; step(); trigger = 1'b0;
            end
         endcase
         step();
      end
   endtask

   initial begin
      test_reset();
      test_countup_and_react();
      test_foul_hold();
      test_foul_final_tick();
      test_timeout();
      test_rst_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
